hd44780_capture: RTL and testbench
==================================

# hd44780_capture

Passive HD44780 responder. It sits on the same three-signal character-LCD bus (RS, E, D[7:0]) that the board's LCD driver writes, and reconstructs the 2×16 visible display contents. The captured contents go into a 32-byte shadow buffer, which the JTAG/simulator side reads to mirror the LCD on the desktop client. It only listens: RW stays grounded and nothing is driven back onto the bus.

## Interface
Parameters:
- `SWEEP_START`, default 0: buffer index where the clear sweep begins. It is always 0 in the current design and is kept only for bench shortening.

Ports:
- `clk`  in  1: system clock, 50 MHz (`FPGA_CLK1_50`).
- `reset`  in  1: asynchronous, active-high.
- `lcd_rs`  in  1: bus RS (0 = instruction, 1 = data). Asynchronous to `clk`.
- `lcd_e`  in  1: bus enable. Strobes on its falling edge. Asynchronous.
- `lcd_d`  in  8: bus data. Asynchronous.
- `rd_addr`  in  5: shadow read index. Bit 4 = row, bits [3:0] = column.
- `rd_data`  out  8: registered character at `rd_addr`.
- `busy`  out  1: a clear sweep is in progress.
- `changed`  out  1: sticky flag, set by any visible-cell write or clear.
- `changed_clr`  in  1: clears `changed`. A set event in the same cycle wins.
- `overflow`  out  1: sticky flag, set when a strobe is lost. Cleared only by reset.
- `display_on`  out  1: D bit from the last display-control instruction.

## Operation
- **Synchronization:** `lcd_e`, `lcd_rs` and `lcd_d` pass through the same 2-flop synchronizer, so they stay aligned. A strobe is the cycle where the synced E goes 1→0. RS/D are taken from the synced stage in that same cycle. The bus must hold RS/D stable for ≥2 clk after E falls.
- **State:**
  - `ddram_addr[6:0]`.
  - `inc` (entry I/D).
  - `cg_mode` (1 after a CGRAM-address instruction).
  - Pending slot, one entry.
  - Sweep counter, 5 bits.
- **Instruction decode** (RS=0), highest set bit wins:
  - 1xxxxxxx: `ddram_addr` <= D[6:0], `cg_mode` <= 0.
  - 01xxxxxx: `cg_mode` <= 1.
  - 001xxxxx: function set, ignored.
  - 0001 S/C R/L xx: if S/C=0, move the address by ±1 using the wrap rule. If S/C=1 (display shift), ignored.
  - 00001 D C B: `display_on` <= D.
  - 000001 I/D S: `inc` <= I/D. S is ignored.
  - 0000001x: `ddram_addr` <= 0.
  - 00000001: clear. Starts a sweep, sets `ddram_addr` <= 0 and `inc` <= 1.
  - 00000000: ignored.
- **Data write** (RS=1):
  - If `cg_mode`: the data is discarded and nothing else changes.
  - Otherwise the cell is visible when addr[5:4]==00. Its index is {addr[6], addr[3:0]}. A visible cell is written with D and sets `changed`.
  - An invisible address is not written.
  - In both the visible and invisible cases the address then steps by ±1.
- **Address wrap (2-line mode):**
  - Increment: 0x27→0x40 and 0x67→0x00.
  - Decrement: 0x00→0x67 and 0x40→0x27.
  - Any other value steps by ±1 within its line.
- **States:**
  - IDLE: strobes execute.
  - SWEEP: writes 0x20 to index `cnt`, one cell per cycle for 32 cycles. `busy`=1. When `cnt`==31 it returns to IDLE.
- **Strobes during SWEEP:**
  - The first is stored in the pending slot and executes in the first IDLE cycle.
  - A further strobe while the slot is full is dropped and sets `overflow`.
- **Reset:** reset enters SWEEP at `cnt`=0, so the buffer initializes to spaces with no RAM reset.

## Timing
- Reset values:
  - `rd_data`=0x00, `busy`=1, `changed`=0, `overflow`=0, `display_on`=0.
  - `ddram_addr`=0, `inc`=1, `cg_mode`=0, pending empty.
  - State is SWEEP with `cnt`=0.
- After reset release, `busy` stays high for exactly 32 clocks.
- Strobe latency: E falls at input edge T. The strobe is detected at T+2, and the write/instruction takes effect at edge T+3.
- `rd_data` follows `rd_addr` with 1-cycle registered latency (read-after-write returns new data).
- A clear instruction executed at edge T asserts `busy` from T; cells are written at T..T+31, and `busy` falls at T+32.
- Pending execution: runs in the cycle after `busy` falls, with the same effect as a normal strobe.
- Reset mid-sweep or mid-strobe: everything returns to reset values and a fresh 32-cycle sweep starts.

## Configuration
- `HD44780_CURSOR_EN` defined adds these outputs:
  - `cursor_on` (C bit) and `cursor_blink` (B bit), both from display control. Reset value 0.
  - `cursor_idx[4:0]`, equal to {addr[6], addr[3:0]}.
  - `cursor_vis`, equal to (addr[5:4]==00 && !`cg_mode`).
- Undefined: these ports do not exist and the C/B bits are ignored.

## Test plan
- **Reset init:** release reset, wait 32 clk, then read all 32 indices → 0x20 each. `busy` must fall at cycle 32.
- **Line-2 write:** send instruction 0xC5, then data 0x41 ('A') → index 21 = 0x41 and `changed`=1.
- **Wrap:** set 0xA7 (addr 0x27), write 'X' then 'Y' → 'Y' lands at index 16 (addr 0x40). 'X' is invisible, so no cell changes for it.
- **Decrement mode:** send entry 0x04, set 0x80, write 'Q' → index 0 = 'Q', and the next data lands at addr 0x67 (invisible).
- **Clear plus queue:** with data present, send 0x01, then 2 data strobes during `busy` → `overflow`=1; afterwards index 0 holds the first queued char and the rest are 0x20.
- **CGRAM:** send 0x40, then 8 data bytes → no cell changes and `changed` stays 0; then 0x80 plus 'Z' → index 0 = 'Z'.

Source files
------------

// File: rtl/hd44780_capture.sv
// hd44780_capture
//
// Passive HD44780 bus listener. Watches RS/E/D written by the board's LCD
// driver and rebuilds the 2x16 visible character area in a 32-byte shadow
// buffer. The host side reads the shadow through rd_addr/rd_data. Nothing is
// ever driven back onto the LCD bus.
//
// Ports
//   clk, reset        50 MHz system clock, async active-high reset
//   lcd_rs/e/d        LCD bus, asynchronous to clk; E strobes on its falling edge
//   rd_addr[4:0]      shadow index {row, column[3:0]}
//   rd_data[7:0]      registered shadow byte at rd_addr (1-cycle latency)
//   busy              clear sweep in progress
//   changed           sticky: visible cell written or display cleared
//   changed_clr       clears changed (a simultaneous set wins)
//   overflow          sticky: a strobe was dropped (cleared only by reset)
//   display_on        D bit of the last display-control instruction
//
// Optional build macro HD44780_CURSOR_EN adds:
//   cursor_on, cursor_blink, cursor_idx[4:0], cursor_vis
//
// state  | meaning
// IDLE   | strobes (or the pending one) execute
// SWEEP  | writes 0x20 to one cell per cycle, 32 cycles, busy=1

module hd44780_capture #(
    parameter int unsigned SWEEP_START = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_rs,
    input  logic       lcd_e,
    input  logic [7:0] lcd_d,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       changed,
    input  logic       changed_clr,
    output logic       overflow,
    output logic       display_on
`ifdef HD44780_CURSOR_EN
    ,
    output logic       cursor_on,
    output logic       cursor_blink,
    output logic [4:0] cursor_idx,
    output logic       cursor_vis
`endif
);

    localparam logic       ST_IDLE    = 1'b0;
    localparam logic       ST_SWEEP   = 1'b1;
    localparam logic [4:0] SWEEP_BASE = 5'(SWEEP_START);
    localparam logic [7:0] SPACE      = 8'h20;

    // {E, RS, D} travel through one synchronizer so they stay aligned.
    logic [9:0] sync1_q, sync1_d;
    logic [9:0] sync2_q, sync2_d;
    logic       e_prev_q, e_prev_d;

    logic       strobe_q, strobe_d;
    logic       st_rs_q, st_rs_d;
    logic [7:0] st_data_q, st_data_d;

    logic       pend_v_q, pend_v_d;
    logic       pend_rs_q, pend_rs_d;
    logic [7:0] pend_data_q, pend_data_d;

    logic       state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [6:0] addr_q, addr_d;
    logic       inc_q, inc_d;
    logic       cg_q, cg_d;
    logic       changed_q, changed_d;
    logic       overflow_q, overflow_d;
    logic       disp_q, disp_d;
    logic       curs_q, curs_d;
    logic       blink_q, blink_d;
    logic [7:0] rd_data_q, rd_data_d;

    logic       exec_v;
    logic       exec_rs;
    logic [7:0] exec_data;
    logic       wr_en;
    logic [4:0] wr_idx;
    logic [7:0] wr_data;

    logic [7:0] mem [32];

    // Two-line DDRAM address stepping: line 1 is 0x00-0x27, line 2 0x40-0x67.
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    always_comb begin
        sync1_d     = {lcd_e, lcd_rs, lcd_d};
        sync2_d     = sync1_q;
        e_prev_d    = sync2_q[9];

        strobe_d    = e_prev_q & ~sync2_q[9];
        st_rs_d     = sync2_q[8];
        st_data_d   = sync2_q[7:0];

        pend_v_d    = pend_v_q;
        pend_rs_d   = pend_rs_q;
        pend_data_d = pend_data_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        inc_d       = inc_q;
        cg_d        = cg_q;
        changed_d   = changed_q & ~changed_clr;
        overflow_d  = overflow_q;
        disp_d      = disp_q;
        curs_d      = curs_q;
        blink_d     = blink_q;

        exec_v      = 1'b0;
        exec_rs     = 1'b0;
        exec_data   = 8'h00;
        wr_en       = 1'b0;
        wr_idx      = 5'd0;
        wr_data     = 8'h00;

        if (state_q == ST_SWEEP) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_q;
            wr_data = SPACE;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = ST_IDLE;
            if (strobe_q) begin
                if (!pend_v_q) begin
                    pend_v_d    = 1'b1;
                    pend_rs_d   = st_rs_q;
                    pend_data_d = st_data_q;
                end else begin
                    overflow_d  = 1'b1;
                end
            end
        end else begin
            if (pend_v_q) begin
                exec_v    = 1'b1;
                exec_rs   = pend_rs_q;
                exec_data = pend_data_q;
                // The slot frees as it executes, so a strobe arriving now refills it.
                pend_v_d  = strobe_q;
                if (strobe_q) begin
                    pend_rs_d   = st_rs_q;
                    pend_data_d = st_data_q;
                end
            end else if (strobe_q) begin
                exec_v    = 1'b1;
                exec_rs   = st_rs_q;
                exec_data = st_data_q;
            end
        end

        if (exec_v) begin
            if (exec_rs) begin
                if (!cg_q) begin
                    if (addr_q[5:4] == 2'b00) begin
                        wr_en     = 1'b1;
                        wr_idx    = {addr_q[6], addr_q[3:0]};
                        wr_data   = exec_data;
                        changed_d = 1'b1;
                    end
                    addr_d = addr_step(addr_q, inc_q);
                end
            end else begin
                if (exec_data[7]) begin
                    addr_d = exec_data[6:0];
                    cg_d   = 1'b0;
                end else if (exec_data[6]) begin
                    cg_d = 1'b1;
                end else if (exec_data[5]) begin
                    // function set: no effect on the shadow
                end else if (exec_data[4]) begin
                    if (!exec_data[3]) addr_d = addr_step(addr_q, exec_data[2]);
                end else if (exec_data[3]) begin
                    disp_d  = exec_data[2];
                    curs_d  = exec_data[1];
                    blink_d = exec_data[0];
                end else if (exec_data[2]) begin
                    inc_d = exec_data[1];
                end else if (exec_data[1]) begin
                    addr_d = 7'h00;
                end else if (exec_data[0]) begin
                    state_d   = ST_SWEEP;
                    cnt_d     = SWEEP_BASE;
                    addr_d    = 7'h00;
                    inc_d     = 1'b1;
                    changed_d = 1'b1;
                end
            end
        end

        // Bypass so a read of the cell being written returns the new byte.
        if (wr_en && (wr_idx == rd_addr)) rd_data_d = wr_data;
        else                              rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            e_prev_q    <= 1'b0;
            strobe_q    <= 1'b0;
            st_rs_q     <= 1'b0;
            st_data_q   <= 8'h00;
            pend_v_q    <= 1'b0;
            pend_rs_q   <= 1'b0;
            pend_data_q <= 8'h00;
            state_q     <= ST_SWEEP;
            cnt_q       <= SWEEP_BASE;
            addr_q      <= 7'h00;
            inc_q       <= 1'b1;
            cg_q        <= 1'b0;
            changed_q   <= 1'b0;
            overflow_q  <= 1'b0;
            disp_q      <= 1'b0;
            curs_q      <= 1'b0;
            blink_q     <= 1'b0;
            rd_data_q   <= 8'h00;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            e_prev_q    <= e_prev_d;
            strobe_q    <= strobe_d;
            st_rs_q     <= st_rs_d;
            st_data_q   <= st_data_d;
            pend_v_q    <= pend_v_d;
            pend_rs_q   <= pend_rs_d;
            pend_data_q <= pend_data_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            inc_q       <= inc_d;
            cg_q        <= cg_d;
            changed_q   <= changed_d;
            overflow_q  <= overflow_d;
            disp_q      <= disp_d;
            curs_q      <= curs_d;
            blink_q     <= blink_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Shadow RAM has no reset; the reset sweep fills it with spaces.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    assign rd_data    = rd_data_q;
    assign busy       = (state_q == ST_SWEEP);
    assign changed    = changed_q;
    assign overflow   = overflow_q;
    assign display_on = disp_q;

`ifdef HD44780_CURSOR_EN
    assign cursor_on    = curs_q;
    assign cursor_blink = blink_q;
    assign cursor_idx   = {addr_q[6], addr_q[3:0]};
    assign cursor_vis   = (addr_q[5:4] == 2'b00) && !cg_q;
`else
    // C/B bits are decoded but unused without the cursor outputs.
    logic unused_cursor;
    assign unused_cursor = curs_q ^ blink_q;
`endif

endmodule

// File: tb/tb_hd44780_capture.sv
module tb_hd44780_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lcd_rs = 1'b0;
    logic       lcd_e = 1'b0;
    logic [7:0] lcd_d = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_data;
    logic       busy;
    logic       changed;
    logic       changed_clr = 1'b0;
    logic       overflow;
    logic       display_on;
`ifdef HD44780_CURSOR_EN
    logic       cursor_on;
    logic       cursor_blink;
    logic [4:0] cursor_idx;
    logic       cursor_vis;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    hd44780_capture #(.SWEEP_START(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .lcd_rs      (lcd_rs),
        .lcd_e       (lcd_e),
        .lcd_d       (lcd_d),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .changed     (changed),
        .changed_clr (changed_clr),
        .overflow    (overflow),
        .display_on  (display_on)
`ifdef HD44780_CURSOR_EN
        ,
        .cursor_on   (cursor_on),
        .cursor_blink(cursor_blink),
        .cursor_idx  (cursor_idx),
        .cursor_vis  (cursor_vis)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One LCD bus cycle: E high for 3 clocks, RS/D held 6 clocks after E falls.
    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs;
        lcd_d  = d;
        lcd_e  = 1'b1;
        repeat (3) @(negedge clk);
        lcd_e = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic read_cell(input logic [4:0] idx, output logic [7:0] v);
        @(negedge clk);
        rd_addr = idx;
        @(posedge clk);
        #1 v = rd_data;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        changed_clr = 1'b1;
        @(negedge clk);
        changed_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] v;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h01);
        chk("rst_changed", {7'd0, changed}, 8'h00);
        chk("rst_overflow", {7'd0, overflow}, 8'h00);
        chk("rst_display_on", {7'd0, display_on}, 8'h00);

        // busy high for exactly 32 clocks after release
        @(negedge clk);
        reset = 1'b0;
        repeat (31) @(posedge clk);
        #1 chk("init_busy_31", {7'd0, busy}, 8'h01);
        @(posedge clk);
        #1 chk("init_busy_32", {7'd0, busy}, 8'h00);
        for (int i = 0; i < 32; i++) begin
            read_cell(5'(i), v);
            chk($sformatf("init_cell_%0d", i), v, 8'h20);
        end
        chk("init_changed", {7'd0, changed}, 8'h00);

        // Line-2 write and display control
        bus_write(1'b0, 8'h0C);
        chk("disp_on", {7'd0, display_on}, 8'h01);
        bus_write(1'b0, 8'hC5);
        bus_write(1'b1, 8'h41);
        read_cell(5'd21, v);
        chk("line2_idx21", v, 8'h41);
        chk("line2_changed", {7'd0, changed}, 8'h01);
        pulse_clr();
        chk("changed_clr", {7'd0, changed}, 8'h00);

        // Wrap 0x27 -> 0x40
        bus_write(1'b0, 8'hA7);
        bus_write(1'b1, 8'h58);
        chk("wrap_x_invisible", {7'd0, changed}, 8'h00);
        read_cell(5'd7, v);
        chk("wrap_idx7", v, 8'h20);
        bus_write(1'b1, 8'h59);
        read_cell(5'd16, v);
        chk("wrap_idx16", v, 8'h59);
        chk("wrap_changed", {7'd0, changed}, 8'h01);

        // Decrement mode: 0x00 -> 0x67
        bus_write(1'b0, 8'h04);
        bus_write(1'b0, 8'h80);
        bus_write(1'b1, 8'h51);
        read_cell(5'd0, v);
        chk("dec_idx0", v, 8'h51);
        bus_write(1'b1, 8'h52);
        read_cell(5'd7, v);
        chk("dec_idx7", v, 8'h20);
        read_cell(5'd23, v);
        chk("dec_idx23", v, 8'h20);
        read_cell(5'd31, v);
        chk("dec_idx31", v, 8'h20);
        chk("pre_clear_overflow", {7'd0, overflow}, 8'h00);

        // Clear plus queued strobes
        bus_write(1'b0, 8'h01);
        chk("clear_busy", {7'd0, busy}, 8'h01);
        bus_write(1'b1, 8'h4D);
        bus_write(1'b1, 8'h4E);
        chk("clear_still_busy", {7'd0, busy}, 8'h01);
        repeat (40) @(negedge clk);
        chk("clear_done", {7'd0, busy}, 8'h00);
        chk("clear_overflow", {7'd0, overflow}, 8'h01);
        read_cell(5'd0, v);
        chk("queue_idx0", v, 8'h4D);
        read_cell(5'd1, v);
        chk("queue_idx1", v, 8'h20);
        read_cell(5'd16, v);
        chk("clear_idx16", v, 8'h20);
        read_cell(5'd21, v);
        chk("clear_idx21", v, 8'h20);
        bus_write(1'b1, 8'h4B);
        read_cell(5'd1, v);
        chk("clear_inc_idx1", v, 8'h4B);

        // CGRAM writes are discarded
        pulse_clr();
        bus_write(1'b0, 8'h40);
        for (int i = 0; i < 8; i++) bus_write(1'b1, 8'hFF);
        chk("cg_changed", {7'd0, changed}, 8'h00);
        read_cell(5'd1, v);
        chk("cg_idx1", v, 8'h4B);
        read_cell(5'd2, v);
        chk("cg_idx2", v, 8'h20);
        bus_write(1'b0, 8'h80);
        bus_write(1'b1, 8'h5A);
        read_cell(5'd0, v);
        chk("cg_exit_idx0", v, 8'h5A);
        chk("cg_exit_changed", {7'd0, changed}, 8'h01);

        // Return home, cursor shift right, display off
        bus_write(1'b0, 8'h02);
        bus_write(1'b1, 8'h48);
        read_cell(5'd0, v);
        chk("home_idx0", v, 8'h48);
        bus_write(1'b0, 8'h14);
        bus_write(1'b1, 8'h4A);
        read_cell(5'd2, v);
        chk("shift_idx2", v, 8'h4A);
        read_cell(5'd1, v);
        chk("shift_idx1", v, 8'h4B);
        bus_write(1'b0, 8'h08);
        chk("disp_off", {7'd0, display_on}, 8'h00);

        // Reset mid-operation
        bus_write(1'b0, 8'h0C);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_busy", {7'd0, busy}, 8'h01);
        chk("rst2_overflow", {7'd0, overflow}, 8'h00);
        chk("rst2_changed", {7'd0, changed}, 8'h00);
        chk("rst2_display_on", {7'd0, display_on}, 8'h00);
        reset = 1'b0;
        repeat (33) @(negedge clk);
        chk("rst2_done", {7'd0, busy}, 8'h00);
        read_cell(5'd0, v);
        chk("rst2_idx0", v, 8'h20);
        read_cell(5'd2, v);
        chk("rst2_idx2", v, 8'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
